regfile_mp: RTL and testbench

- Parametrised multi-port successor to the single-issue register file.
- Provides NR synchronous read ports, two prioritised write ports, write-through bypass, an optional hardwired-zero register 0, and a per-register busy scoreboard for the pipeline hazard unit.
- Sits between decode (reads, issue) and writeback (two result buses).
- The debug read port is on the same clock domain.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 46 ++++
 rtl/regfile_mp.sv | 113 +++++++++++
 tb/tb_regfile_mp.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and reset-value helper for the multi-port register file.
package regfile_pkg;

    localparam int DW_DEFAULT    = 32;
    localparam int DEPTH_DEFAULT = 32;
    localparam int NR_DEFAULT    = 2;

    localparam bit RESET_MODE_ZERO  = 1'b0;
    localparam bit RESET_MODE_INDEX = 1'b1;

    function automatic int unsigned reset_value(input int unsigned idx, input bit mode);
        return (mode == RESET_MODE_INDEX) ? idx : 32'd0;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy vector for the hazard unit, with registered multi-port lookup.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH),
    parameter int NR    = NR_DEFAULT
) (
    input  logic             clk,
    input  logic             res,
    input  logic             set_en,
    input  logic [AW-1:0]    set_add,
    input  logic             clr0_en,
    input  logic [AW-1:0]    clr0_add,
    input  logic             clr1_en,
    input  logic [AW-1:0]    clr1_add,
    input  logic [NR*AW-1:0] radd,
    input  logic [NR-1:0]    rd_ok,
    output logic [NR-1:0]    rbusy
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    // Callers only assert the enables for in-range, writable addresses.
    always_comb begin
        busy_nxt = busy;
        if (clr0_en) busy_nxt[clr0_add] = 1'b0;
        if (clr1_en) busy_nxt[clr1_add] = 1'b0;
        // NOTE: the set is applied last so an issue beats a same-cycle writeback.
        if (set_en)  busy_nxt[set_add]  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            busy  <= '0;
            rbusy <= '0;
        end else begin
            busy <= busy_nxt;
            for (int k = 0; k < NR; k++) begin
                rbusy[k] <= rd_ok[k] && busy_nxt[radd[k*AW +: AW]];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NR bypassed read ports, two prioritised write ports,
// debug read port and issue/writeback busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW          = DW_DEFAULT,
    parameter int DEPTH       = DEPTH_DEFAULT,
    parameter int AW          = $clog2(DEPTH),
    parameter int NR          = NR_DEFAULT,
    parameter int ZERO_REG    = 1,
    parameter int RESET_INDEX = 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic [NR*AW-1:0] radd,
    output logic [NR*DW-1:0] dout,
    output logic [NR-1:0]    rbusy,
    input  logic             wen0,
    input  logic [AW-1:0]    wadd0,
    input  logic [DW-1:0]    wdi0,
    input  logic             wen1,
    input  logic [AW-1:0]    wadd1,
    input  logic [DW-1:0]    wdi1,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_add,
    input  logic [AW-1:0]    radd_debug,
    output logic [DW-1:0]    dout_debug
);

    localparam int          NP        = NR + 1;   // read ports plus the debug port
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    logic [DW-1:0] regs    [DEPTH];
    logic [AW-1:0] rd_addr [NP];
    logic [DW-1:0] rd_data [NP];
    logic [NP-1:0] rd_ok;
    logic          we0_ok;
    logic          we1_ok;
    logic          iss_ok;

    // Address holds real state: in range and not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_LIM) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign we0_ok = wen0   && addr_ok(wadd0);
    assign we1_ok = wen1   && addr_ok(wadd1);
    assign iss_ok = iss_en && addr_ok(iss_add);

    always_comb begin
        for (int k = 0; k < NR; k++) begin
            rd_addr[k] = radd[k*AW +: AW];
        end
        rd_addr[NR] = radd_debug;
    end

    // Write-through: a read sees this edge's write, port 1 ahead of port 0.
    always_comb begin
        for (int k = 0; k < NP; k++) begin
            rd_ok[k]   = addr_ok(rd_addr[k]);
            rd_data[k] = '0;
            if (rd_ok[k]) begin
                if (we1_ok && wadd1 == rd_addr[k])      rd_data[k] = wdi1;
                else if (we0_ok && wadd0 == rd_addr[k]) rd_data[k] = wdi0;
                else                                    rd_data[k] = regs[rd_addr[k]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            // NOTE: the whole array has a reset value, so it is built from flops, not a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= DW'(reset_value(i, RESET_INDEX != 0));
            end
        end else begin
            if (we0_ok) regs[wadd0] <= wdi0;
            // NOTE: the later non-blocking assignment wins, giving port 1 priority on a shared address.
            if (we1_ok) regs[wadd1] <= wdi1;
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            dout       <= '0;
            dout_debug <= '0;
        end else begin
            for (int k = 0; k < NR; k++) begin
                dout[k*DW +: DW] <= rd_data[k];
            end
            dout_debug <= rd_data[NR];
        end
    end

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .NR    (NR)
    ) u_scoreboard (
        .clk      (clk),
        .res      (res),
        .set_en   (iss_ok),
        .set_add  (iss_add),
        .clr0_en  (we0_ok),
        .clr0_add (wadd0),
        .clr1_en  (we1_ok),
        .clr1_add (wadd1),
        .radd     (radd),
        .rd_ok    (rd_ok[NR-1:0]),
        .rbusy    (rbusy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a default instance and a DEPTH=24/NR=3/DW=16/no-zero-reg
// instance share stimulus; an array-based reference model predicts both.
module tb_regfile_mp;

    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          res;
    logic          wen0;
    logic          wen1;
    logic          iss_en;
    logic [AW-1:0] wadd0;
    logic [AW-1:0] wadd1;
    logic [AW-1:0] iss_add;
    logic [AW-1:0] radd_debug;
    logic [31:0]   wdi0;
    logic [31:0]   wdi1;
    logic [AW-1:0] ra [3];

    logic [2*AW-1:0] radd_a;
    logic [63:0]     dout_a;
    logic [1:0]      rbusy_a;
    logic [31:0]     dbg_a;
    logic [3*AW-1:0] radd_b;
    logic [47:0]     dout_b;
    logic [2:0]      rbusy_b;
    logic [15:0]     dbg_b;

    assign radd_a = {ra[1], ra[0]};
    assign radd_b = {ra[2], ra[1], ra[0]};

    regfile_mp #(
        .DW(32), .DEPTH(32), .NR(2), .ZERO_REG(1), .RESET_INDEX(1)
    ) dut_a (
        .clk        (clk),
        .res        (res),
        .radd       (radd_a),
        .dout       (dout_a),
        .rbusy      (rbusy_a),
        .wen0       (wen0),
        .wadd0      (wadd0),
        .wdi0       (wdi0),
        .wen1       (wen1),
        .wadd1      (wadd1),
        .wdi1       (wdi1),
        .iss_en     (iss_en),
        .iss_add    (iss_add),
        .radd_debug (radd_debug),
        .dout_debug (dbg_a)
    );

    regfile_mp #(
        .DW(16), .DEPTH(24), .NR(3), .ZERO_REG(0), .RESET_INDEX(1)
    ) dut_b (
        .clk        (clk),
        .res        (res),
        .radd       (radd_b),
        .dout       (dout_b),
        .rbusy      (rbusy_b),
        .wen0       (wen0),
        .wadd0      (wadd0),
        .wdi0       (wdi0[15:0]),
        .wen1       (wen1),
        .wadd1      (wadd1),
        .wdi1       (wdi1[15:0]),
        .iss_en     (iss_en),
        .iss_add    (iss_add),
        .radd_debug (radd_debug),
        .dout_debug (dbg_b)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] d [3];
        logic [2:0]  b;
        logic [31:0] dbg;
        string       label;
    } exp_t;

    exp_t        q_a [$];
    exp_t        q_b [$];
    int unsigned m_reg  [2][32];
    bit          m_busy [2][32];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic int depth_of(input int i);
        return (i == 0) ? 32 : 24;
    endfunction

    function automatic int ports_of(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int unsigned mask_of(input int i);
        return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    // Register i holds real state: in range, and not register 0 on the zero-reg instance.
    function automatic bit live(input int i, input int a);
        return (a < depth_of(i)) && !(i == 0 && a == 0);
    endfunction

    task automatic model_cycle(input int i, input string label, output exp_t e);
        e.label = label;
        e.b     = '0;
        e.dbg   = '0;
        for (int p = 0; p < 3; p++) e.d[p] = '0;
        if (!res) begin
            for (int r = 0; r < 32; r++) begin
                m_reg[i][r]  = r & mask_of(i);
                m_busy[i][r] = 1'b0;
            end
            return;
        end
        if (wen0 && live(i, int'(wadd0))) m_reg[i][wadd0] = wdi0 & mask_of(i);
        if (wen1 && live(i, int'(wadd1))) m_reg[i][wadd1] = wdi1 & mask_of(i);
        if (wen0 && live(i, int'(wadd0))) m_busy[i][wadd0] = 1'b0;
        if (wen1 && live(i, int'(wadd1))) m_busy[i][wadd1] = 1'b0;
        if (iss_en && live(i, int'(iss_add))) m_busy[i][iss_add] = 1'b1;
        for (int p = 0; p < ports_of(i); p++) begin
            if (live(i, int'(ra[p]))) begin
                e.d[p] = m_reg[i][ra[p]];
                e.b[p] = m_busy[i][ra[p]];
            end
        end
        if (live(i, int'(radd_debug))) e.dbg = m_reg[i][radd_debug];
    endtask

    // Predict this cycle's outputs for both instances, then let the edge happen.
    task automatic tick(input string label);
        exp_t ea;
        exp_t eb;
        model_cycle(0, label, ea);
        model_cycle(1, label, eb);
        q_a.push_back(ea);
        q_b.push_back(eb);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    exp_t mon_a;
    exp_t mon_b;

    always @(posedge clk) begin
        #1;
        if (q_a.size() > 0) begin
            mon_a = q_a.pop_front();
            for (int p = 0; p < 2; p++) begin
                check($sformatf("A %s dout[%0d]", mon_a.label, p), dout_a[p*32 +: 32], mon_a.d[p]);
                check($sformatf("A %s rbusy[%0d]", mon_a.label, p), 32'(rbusy_a[p]), 32'(mon_a.b[p]));
            end
            check($sformatf("A %s dout_debug", mon_a.label), dbg_a, mon_a.dbg);
        end
        if (q_b.size() > 0) begin
            mon_b = q_b.pop_front();
            for (int p = 0; p < 3; p++) begin
                check($sformatf("B %s dout[%0d]", mon_b.label, p), 32'(dout_b[p*16 +: 16]), mon_b.d[p]);
                check($sformatf("B %s rbusy[%0d]", mon_b.label, p), 32'(rbusy_b[p]), 32'(mon_b.b[p]));
            end
            check($sformatf("B %s dout_debug", mon_b.label), 32'(dbg_b), mon_b.dbg);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        res    = 1'b1;
        wen0   = 1'b0;
        wen1   = 1'b0;
        iss_en = 1'b0;
    endtask

    initial begin
        idle();
        wadd1 = '0; wdi1 = '0; iss_add = '0;
        res = 1'b0; wen0 = 1'b1; wadd0 = 5'd5; wdi0 = 32'hFFFF_FFFF;
        ra[0] = 5'd5; ra[1] = 5'd31; ra[2] = 5'd0; radd_debug = 5'd5;
        tick("reset");

        idle(); radd_debug = 5'd31;
        tick("post_reset");
        ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd23; radd_debug = 5'd23;
        tick("index_read");

        wen0 = 1'b1; wadd0 = 5'd7; wdi0 = 32'hDEAD_BEEF; ra[0] = 5'd7; radd_debug = 5'd7;
        tick("write_through");
        idle();
        tick("reread7");

        wen0 = 1'b1; wadd0 = 5'd9; wdi0 = 32'h11;
        wen1 = 1'b1; wadd1 = 5'd9; wdi1 = 32'h22;
        ra[0] = 5'd9; ra[1] = 5'd9; radd_debug = 5'd9;
        tick("collision");
        idle();
        tick("collision_hold");

        wen1 = 1'b1; wadd1 = 5'd0; wdi1 = 32'h1234; iss_en = 1'b1; iss_add = 5'd0;
        ra[0] = 5'd0; ra[1] = 5'd0; ra[2] = 5'd0; radd_debug = 5'd0;
        tick("zero_reg");
        idle();
        tick("zero_reg_hold");

        iss_en = 1'b1; iss_add = 5'd12; ra[0] = 5'd3; ra[1] = 5'd3; ra[2] = 5'd3;
        tick("issue12");
        idle(); ra[0] = 5'd12; ra[2] = 5'd12;
        tick("busy12");
        wen0 = 1'b1; wadd0 = 5'd12; wdi0 = 32'h0BAD_F00D; iss_en = 1'b1; iss_add = 5'd12;
        tick("wb_and_issue12");
        idle();
        tick("still_busy12");
        wen1 = 1'b1; wadd1 = 5'd12; wdi1 = 32'h0000_C0DE;
        tick("wb12");
        idle();
        tick("clear12");

        wen0 = 1'b1; wadd0 = 5'd30; wdi0 = 32'hAAAA_5555; ra[2] = 5'd30; radd_debug = 5'd30;
        tick("oor_write");
        idle();
        tick("oor_read");

        for (int n = 0; n < 400; n++) begin
            res    = ($urandom_range(0, 63) != 0);
            wen0   = 1'($urandom_range(0, 1));
            wen1   = 1'($urandom_range(0, 1));
            iss_en = 1'($urandom_range(0, 1));
            wadd0  = 5'($urandom_range(0, 31));
            wadd1  = ($urandom_range(0, 3) == 0) ? wadd0 : 5'($urandom_range(0, 31));
            iss_add = ($urandom_range(0, 3) == 0) ? wadd1 : 5'($urandom_range(0, 31));
            wdi0   = $urandom;
            wdi1   = $urandom;
            for (int p = 0; p < 3; p++) begin
                ra[p] = ($urandom_range(0, 2) == 0) ? wadd0 : 5'($urandom_range(0, 31));
            end
            radd_debug = ($urandom_range(0, 2) == 0) ? wadd1 : 5'($urandom_range(0, 31));
            tick("random");
        end

        idle();
        for (int c = 0; c < 5 && (q_a.size() + q_b.size()) != 0; c++) @(negedge clk);
        check("drain", 32'(q_a.size() + q_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
